// File: rtl/hash_core_arbiter.sv
// Round-robin arbiter that lends one shared byte-serial hash core to NREQ requesters.
// Optional stall timeout with zero padding and abort: define HASH_ARB_TIMEOUT_EN.
module hash_core_arbiter #(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned LEN_W       = 64,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*LEN_W-1:0]   req_len,
  input  logic [NREQ-1:0]         byte_valid,
  input  logic [NREQ*8-1:0]       byte_data,
  output logic [NREQ-1:0]         byte_ready,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic [NREQ-1:0]         abort,
  output logic [31:0]             digest_out,
  output logic                    core_m_valid,
  output logic [7:0]              core_message,
  output logic [LEN_W-1:0]        core_counter,
  input  logic                    core_hash_ready,
  input  logic [31:0]             core_digest
);

  localparam int unsigned PTR_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 4 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("hash_core_arbiter: unsupported parameter set");
  end

  typedef enum logic [2:0] {StIdle, StLoad, StStream, StWait, StDone} state_e;

  state_e             state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [LEN_W-1:0]   remaining_q;
  logic               seen_low_q;

  logic [PTR_W-1:0]   win_idx;
  int unsigned        cand;
  logic [LEN_W-1:0]   sel_len;
  logic [7:0]         sel_byte;
  logic               emit;
  logic [7:0]         emit_byte;

`ifdef HASH_ARB_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0] stall_q;
  logic               pad_q;
  logic               aborted_q;
`else
  assign abort = '0;
`endif

  // Search from ptr+1 upwards with wrap; iterating backwards lets the nearest candidate win.
  always_comb begin
    win_idx = ptr_q;
    cand    = 0;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      cand = (32'(ptr_q) + k) % NREQ;
      if (req_valid[cand]) win_idx = PTR_W'(cand);
    end
  end

  always_comb begin
    sel_len   = req_len[LEN_W*int'(ptr_q) +: LEN_W];
    sel_byte  = byte_data[8*int'(ptr_q) +: 8];
    emit      = byte_valid[ptr_q] & byte_ready[ptr_q];
    emit_byte = sel_byte;
`ifdef HASH_ARB_TIMEOUT_EN
    if (pad_q) begin
      emit      = 1'b1;
      emit_byte = 8'h00;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ptr_q        <= PTR_W'(NREQ - 1);
      remaining_q  <= '0;
      seen_low_q   <= 1'b0;
      grant        <= '0;
      done         <= '0;
      byte_ready   <= '0;
      digest_out   <= '0;
      core_m_valid <= 1'b0;
      core_message <= '0;
      core_counter <= '0;
`ifdef HASH_ARB_TIMEOUT_EN
      abort        <= '0;
      stall_q      <= '0;
      pad_q        <= 1'b0;
      aborted_q    <= 1'b0;
`endif
    end else begin
      core_m_valid <= 1'b0;
      done         <= '0;
`ifdef HASH_ARB_TIMEOUT_EN
      abort        <= '0;
`endif
      unique case (state_q)
        StIdle: begin
          if (|req_valid) begin
            grant   <= NREQ'(1) << win_idx;
            ptr_q   <= win_idx;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          core_counter <= sel_len;
          remaining_q  <= sel_len;
          seen_low_q   <= 1'b0;
`ifdef HASH_ARB_TIMEOUT_EN
          stall_q      <= '0;
          pad_q        <= 1'b0;
          aborted_q    <= 1'b0;
`endif
          if (sel_len == '0) begin
            // Core still needs one strobe to finalise an empty message.
            core_m_valid <= 1'b1;
            core_message <= 8'h00;
            state_q      <= StWait;
          end else begin
            byte_ready <= grant;
            state_q    <= StStream;
          end
        end
        StStream: begin
          if (emit) begin
            core_m_valid <= 1'b1;
            core_message <= emit_byte;
            remaining_q  <= remaining_q - LEN_W'(1);
`ifdef HASH_ARB_TIMEOUT_EN
            stall_q      <= '0;
`endif
            if (remaining_q == LEN_W'(1)) begin
              byte_ready <= '0;
              state_q    <= StWait;
            end
          end
`ifdef HASH_ARB_TIMEOUT_EN
          else if (stall_q == STALL_W'(TIMEOUT_CYC - 1)) begin
            byte_ready <= '0;
            pad_q      <= 1'b1;
            aborted_q  <= 1'b1;
          end else begin
            stall_q <= stall_q + STALL_W'(1);
          end
`endif
        end
        StWait: begin
          // Only a low-to-high edge seen inside WAIT completes the message.
          if (!core_hash_ready) begin
            seen_low_q <= 1'b1;
          end else if (seen_low_q) begin
`ifdef HASH_ARB_TIMEOUT_EN
            if (aborted_q) begin
              abort <= grant;
            end else begin
              done       <= grant;
              digest_out <= core_digest;
            end
`else
            done       <= grant;
            digest_out <= core_digest;
`endif
            state_q <= StDone;
          end
        end
        StDone: begin
          grant   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/hash_core_arbiter.md
HASH_CORE_ARBITER -- requirements
Module: hash_core_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 2, giving the number of requesters (legal range 2..4).
REQ-002 The block SHALL have parameter LEN_W, default 64, giving the width of the message byte-length field.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 16, giving the stall limit in cycles (used only with HASH_ARB_TIMEOUT_EN).
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  system clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 req_valid  in  NREQ  requester i has a message pending.
REQ-008 req_len  in  NREQ*LEN_W  byte length of requester i's message; slice i is sampled at grant.
REQ-009 byte_valid  in  NREQ  requester i is offering a message byte.
REQ-010 byte_data  in  NREQ*8  message byte from requester i.
REQ-011 byte_ready  out  NREQ  the arbiter accepts requester i's byte this cycle.
REQ-012 grant  out  NREQ  one-hot owner of the hash core; all zero when idle.
REQ-013 done  out  NREQ  one-cycle pulse: the digest for requester i is on digest_out.
REQ-014 abort  out  NREQ  one-cycle pulse: requester i's message was abandoned (timeout build only).
REQ-015 digest_out  out  32  the last completed digest.
REQ-016 core_m_valid  out  1  byte strobe to the hash core.
REQ-017 core_message  out  8  byte to the hash core.
REQ-018 core_counter  out  LEN_W  real message length to the hash core; held stable for the whole message.
REQ-019 core_hash_ready  in  1  hash core ready flag.
REQ-020 core_digest  in  32  hash core digest.

Function
REQ-021 The FSM SHALL have the states IDLE, LOAD, STREAM, WAIT and DONE, encoded in a single state register.
REQ-022 In IDLE with any req_valid high, the block SHALL pick the winner round-robin, searching from index ptr+1 with wrap, set grant one-hot, set ptr to the winner, and go to LOAD.
REQ-023 In LOAD the block SHALL latch the winner's req_len into core_counter and into a LEN_W-bit remaining counter; if the length is zero, go to ZEROLEN handling per REQ-027, otherwise go to STREAM.
REQ-024 In STREAM, byte_ready[g] SHALL equal 1 while remaining is nonzero; no other byte_ready bit is ever high.
REQ-025 On each byte handshake (byte_valid[g] and byte_ready[g]), the block SHALL register core_m_valid=1 and core_message=byte_data[g] on the next cycle and decrement remaining.
REQ-026 Gaps in byte_valid SHALL produce core_m_valid=0 cycles; after the handshake that brings remaining to 0, the block SHALL go to WAIT.
REQ-027 For a zero-length message the block SHALL emit exactly one core_m_valid pulse with core_message=0x00, then go to WAIT.
REQ-028 In WAIT the block SHALL go to DONE on the first 0-to-1 transition of core_hash_ready observed after the last core_m_valid; a level already high on entry SHALL NOT count.
REQ-029 In DONE the block SHALL register digest_out from core_digest, pulse done[g] for one cycle, clear grant, and return to IDLE.
REQ-030 Latency from WAIT to done SHALL be one cycle after the detected rising edge.
REQ-031 Once granted, a message is committed: deasserting req_valid[g] SHALL NOT alter the sequence.
REQ-032 Requests arriving during a grant SHALL wait in place; no requester is starved, since each waits at most NREQ-1 messages.
REQ-033 digest_out SHALL hold its value until the next DONE.

Reset
REQ-034 When rst_n=0 at a clock edge, the block SHALL set state=IDLE, ptr=NREQ-1 (so requester 0 wins first), and clear grant, done, abort, byte_ready, core_m_valid, core_message, core_counter, digest_out and remaining.
REQ-035 A reset mid-message SHALL abandon the message without a done or abort pulse; the hash core is reset by the same rst_n.

Configuration
REQ-036 With HASH_ARB_TIMEOUT_EN defined, the block SHALL reach TIMEOUT_CYC consecutive STREAM cycles without a handshake, then deassert byte_ready[g].
REQ-037 On that timeout it SHALL pad the remaining bytes with 0x00, one per cycle, wait as in REQ-028, then pulse abort[g] instead of done[g] and leave digest_out unchanged.
REQ-038 Without HASH_ARB_TIMEOUT_EN, STREAM SHALL wait indefinitely and abort SHALL be tied to 0.

Verification
REQ-039 Requester 0 sends length 3, bytes 0x61 0x62 0x63 -> core_counter=3, three core_m_valid pulses carrying those bytes, done[0] one cycle after the core_hash_ready rise, digest_out=core_digest.
REQ-040 Both req_valid high from reset -> requester 0 served, then requester 1; both high again -> requester 0 served next (alternation).
REQ-041 Requester 1 sends length 0 -> exactly one core_m_valid pulse with 0x00, core_counter=0, then done[1].
REQ-042 Length 4 with byte_valid gaps of 2 cycles -> exactly 4 core_m_valid pulses, no extra bytes, grant held throughout.
REQ-043 rst_n=0 after 2 of 5 bytes -> next cycle all outputs are 0 and state is IDLE; no done pulse.
REQ-044 HASH_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, stall after byte 1 of 3 -> two 0x00 pad bytes, abort[0] pulse, digest_out unchanged.
